// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared types and constants for the UART transmit scheduler.
//   state_t   : scheduler FSM states
//   IDLE_BYTE : value driven on txd_in before any frame has been granted
//   PTR_W     : width of requester index / round-robin pointer (covers up to 8 requesters)
//   rr_next   : pointer that follows a granted index, wrapping at n
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_OK  = 3'd2,
        S_WAIT_END = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam int         PTR_W     = 3;

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Requester handshake and uart_tx side of the scheduler.
//   req_valid/req_data : producers -> scheduler, byte i at [8i+7:8i]
//   req_ready/req_done : scheduler -> producers, one-hot single-cycle pulses
//   tx_start/txd_in    : scheduler -> uart_tx
//   tx_ok              : uart_tx -> scheduler, high while transmitter is in STOP
//   modport master : producer / transmitter side
//   modport slave  : scheduler side
interface uart_tx_sched_if #(parameter int N_REQ = 4);
    import uart_tx_sched_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   req_done;
    logic               tx_start;
    logic [7:0]         txd_in;
    logic               tx_ok;

    modport master (
        output req_valid, req_data, tx_ok,
        input  req_ready, req_done, tx_start, txd_in
    );

    modport slave (
        input  req_valid, req_data, tx_ok,
        output req_ready, req_done, tx_start, txd_in
    );

endinterface

// File: rtl/uart_tx_sched_arbiter.sv
// uart_rr_arbiter
//   Combinational round-robin pick: first asserted request at or after ptr, wrapping.
//   req       in  N_REQ  pending requests
//   ptr       in  PTR_W  highest-priority index (must be < N_REQ)
//   grant     out N_REQ  one-hot winner (all zero when nothing requested)
//   grant_idx out PTR_W  index of winner
//   any       out 1      some request is pending
module uart_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin : pick
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one uart_tx between N_REQ byte requesters, round-robin, with a
//   programmable inter-frame gap and a per-frame watchdog.
//   clk, rst_n  clock, synchronous active-low reset
//   tx_en       transmitter enable; dropping it mid-frame abandons the frame
//   gap_cfg     idle cycles between frames (0 = none)
//   to_cfg      watchdog limit in cycles per frame (0 = disabled)
//   bus         requester handshake + uart_tx side (slave modport)
//   busy        high outside S_IDLE
//   grant_id    index of current / last granted requester
//   abort       single-cycle pulse when a frame is abandoned
//
//   state      | meaning
//   S_IDLE     | waiting for tx_en and a valid request; grant happens here
//   S_START    | tx_start pulse to uart_tx
//   S_WAIT_OK  | waiting for uart_tx to reach STOP (tx_ok high)
//   S_WAIT_END | waiting for tx_ok to fall = frame finished
//   S_GAP      | inter-frame gap, gap_cfg cycles
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GAP_W = 8,
    parameter int TO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic [TO_W-1:0]   to_cfg,
    uart_tx_sched_if.slave    bus,
    output logic              busy,
    output logic [PTR_W-1:0]  grant_id,
    output logic              abort
);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [TO_W-1:0]    wdog;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         txd_q;

    logic [N_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic [7:0]         sel_byte;
    logic               do_grant;
    logic               frame_done;
    logic               timeout;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) sel_byte = bus.req_data[i*8 +: 8];
        end
    end

    assign timeout     = (to_cfg != '0) && (wdog == to_cfg);
    assign bus.txd_in  = txd_q;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Priority in frame states: tx_en drop, then completion, then timeout.
    // A completion and a timeout landing together counts as a completed frame.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.req_done  = '0;
        bus.tx_start  = 1'b0;
        abort         = 1'b0;
        do_grant      = 1'b0;
        frame_done    = 1'b0;
        case (state)
            S_IDLE: begin
                // rst_n gate keeps ready quiet while reset is held
                if (rst_n && tx_en && arb_any) begin
                    bus.req_ready = arb_grant;
                    do_grant      = 1'b1;
                    state_nxt     = S_START;
                end
            end
            S_START, S_WAIT_OK, S_WAIT_END: begin
                if (!tx_en) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (state == S_WAIT_END && !bus.tx_ok) begin
                    frame_done = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant_id == PTR_W'(i)) bus.req_done[i] = 1'b1;
                    end
                    state_nxt = (gap_cfg != '0) ? S_GAP : S_IDLE;
                end else if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    case (state)
                        S_START:   begin
                            bus.tx_start = 1'b1;
                            state_nxt    = S_WAIT_OK;
                        end
                        S_WAIT_OK: if (bus.tx_ok) state_nxt = S_WAIT_END;
                        default:   state_nxt = state;
                    endcase
                end
            end
            S_GAP: begin
                if (!tx_en) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd_q    <= IDLE_BYTE;
            grant_id <= '0;
            rr_ptr   <= '0;
            wdog     <= '0;
            gap_cnt  <= '0;
        end else begin
            if (do_grant) begin
                txd_q    <= sel_byte;
                grant_id <= arb_idx;
                rr_ptr   <= rr_next(arb_idx, N_REQ);
                wdog     <= '0;
            end else if ((state == S_START || state == S_WAIT_OK || state == S_WAIT_END)
                         && wdog != '1) begin
                wdog <= wdog + 1'b1;
            end

            if (frame_done)                          gap_cnt <= gap_cfg;
            else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule
